oven_cook_timer: RTL and testbench
==================================

# oven_cook_timer

Cook-time countdown and heater-enable controller for the electric oven. It sits directly downstream of the APB register bank in `cuptor_electric_top`. It takes the programmed cook time (`timp_setat`), the start/stop commands and the door sensor. It produces the heater enable, the remaining time, a one-cycle timeout pulse and the `mod_ready` LED drive.

## Interface
- `CLK_PER_SEC`, 50: clock cycles per one time unit (second); legal values are ≥ 2.
- `TIME_W`, 8: width of the cook-time and remaining-time fields.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle start/resume command from the register bank.
- `stop`  in  1  one-cycle cancel command.
- `door`  in  1  1 = door closed, 0 = door open.
- `timp_setat`  in  TIME_W  programmed cook time in seconds; sampled only on an accepted start from IDLE.
- `timer_remain`  out  TIME_W  remaining seconds.
- `heat_en`  out  1  heater element enable.
- `timeout`  out  1  one-cycle pulse when the countdown reaches 0.
- `mod_ready`  out  1  LED: cooking finished, food ready.
- `busy`  out  1  high in RUN or PAUSE.

## Operation
- The FSM has four states: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- The prescaler `psc` has width clog2(CLK_PER_SEC) and counts 0..CLK_PER_SEC-1.
- IDLE:
  - If `start & door & timp_setat != 0`: go to RUN, load `timer_remain = timp_setat`, clear `psc`.
  - A start with the door open or with `timp_setat == 0` is ignored; the state stays IDLE.
- RUN:
  - `heat_en = 1`, `busy = 1`.
  - Each cycle `psc` increments.
  - On the cycle where `psc == CLK_PER_SEC-1`, `psc` wraps to 0 and `timer_remain` decrements.
  - If that decrement takes `timer_remain` from 1 to 0: go to DONE and assert `timeout` in the same registered update.
  - Door open (`door == 0`): go to PAUSE. `psc` and `timer_remain` are frozen, and no decrement happens in that cycle even if a wrap was due.
- PAUSE:
  - `heat_en = 0`, `busy = 1`; `psc` and `timer_remain` are held.
  - `start & door`: return to RUN and continue from the held `psc`.
  - Door closing alone does not resume (see Configuration).
- DONE:
  - `mod_ready = 1`, `heat_en = 0`, `timer_remain = 0`.
  - Door open: go to IDLE and clear `mod_ready`.
  - A start while in DONE is ignored.
- `stop` in any state: go to IDLE and clear `timer_remain`, `psc`, `heat_en` and `mod_ready`.
- Priority within one cycle: reset > stop > door open > start > prescaler tick.
- `timer_remain` never underflows. The decrement is gated by `timer_remain != 0`.
- `timp_setat` changes while in RUN or PAUSE have no effect.

## Timing
- Reset values: state IDLE, `timer_remain = 0`, `heat_en = 0`, `timeout = 0`, `mod_ready = 0`, `busy = 0`, `psc = 0`.
- Reset asserted mid-operation takes effect at the next edge. Any pending timeout is lost.
- Start is accepted at edge k. From edge k, `heat_en = 1` and `timer_remain = timp_setat`.
- With no pauses, `timeout` pulses exactly `timp_setat × CLK_PER_SEC` edges after edge k.
- `timer_remain` steps down once every CLK_PER_SEC RUN cycles.
- `timeout` is high for exactly one cycle. `mod_ready` rises on the same edge as `timeout`.
- The door opening at edge j drops `heat_en` at edge j, so the response is registered with one cycle of latency from the input change.
- Cycles spent in PAUSE do not count toward cook time.

## Configuration
- `OVEN_TIMER_AUTORESUME_EN`
  - Defined: in PAUSE, `door == 1` alone returns the FSM to RUN on the next edge; `start` is not required.
  - Undefined: leaving PAUSE requires `start & door`. A start with the door still open is ignored and the FSM stays in PAUSE.
  - DONE and IDLE behaviour is identical in both builds.

## Test plan
- Basic countdown. `CLK_PER_SEC = 4`, `timp_setat = 2`, door closed, start pulse → `heat_en` high for 8 cycles; `timer_remain` goes 2→1→0 at +4 and +8; `timeout` is a single pulse at +8; `mod_ready = 1` until the door opens.
- Pause/resume. `timp_setat = 3`, door open for 5 cycles at cycle 6 → `heat_en` drops, `timer_remain` holds at 2, FSM in PAUSE.
  - Build without the macro: resume only after a start; `timeout` arrives at 12 + 5 + (start delay) cycles.
  - Build with the macro: resume on door close.
- Ignored starts. A start with the door open, and a start with `timp_setat = 0` → state stays IDLE; `heat_en`, `busy` and `timer_remain` stay 0.
- Stop priority. `start` and `stop` in the same cycle in IDLE → stays IDLE. A stop during RUN at `timer_remain = 5` → IDLE next edge; `timer_remain = 0`; no `timeout`.
- Door open on a tick edge. The door opens on the cycle where `psc = 3` with `timer_remain = 1` → PAUSE; `timer_remain` stays 1; no `timeout`.
- Reset mid-run. `reset = 0` for one edge during RUN → all outputs return to their reset values next edge; a later start reloads `timp_setat` normally.

Source files
------------

// File: rtl/oven_cook_timer.sv
// oven_cook_timer
//   Cook-time countdown and heater-enable controller for the electric oven.
//   It loads the programmed cook time on an accepted start and counts it
//   down once per second while the heater runs. It pauses while the door is
//   open and flags completion with a one-cycle timeout pulse plus a latched
//   "food ready" LED.
//
// Parameters
//   CLK_PER_SEC  clock cycles per second (>= 2)
//   TIME_W       width of the cook-time / remaining-time fields
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-low reset
//   start         in   one-cycle start / resume command
//   stop          in   one-cycle cancel command
//   door          in   1 = door closed, 0 = door open
//   timp_setat    in   programmed cook time (s), sampled on start from IDLE
//   timer_remain  out  remaining seconds
//   heat_en       out  heater element enable
//   timeout       out  one-cycle pulse when the countdown reaches 0
//   mod_ready     out  LED: cooking finished, food ready
//   busy          out  high in RUN or PAUSE
//
// Build option
//   OVEN_TIMER_AUTORESUME_EN  when defined, closing the door in PAUSE resumes
//                             cooking without a start command.

module oven_cook_timer #(
  parameter int CLK_PER_SEC = 50,
  parameter int TIME_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              door,
  input  logic [TIME_W-1:0] timp_setat,
  output logic [TIME_W-1:0] timer_remain,
  output logic              heat_en,
  output logic              timeout,
  output logic              mod_ready,
  output logic              busy
);

  localparam int PSC_W = $clog2(CLK_PER_SEC);
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(CLK_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [PSC_W-1:0] psc;
  logic             resume;

  // Condition that takes PAUSE back to RUN.
`ifdef OVEN_TIMER_AUTORESUME_EN
  assign resume = door;
`else
  assign resume = start & door;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      psc          <= '0;
      timer_remain <= '0;
      heat_en      <= 1'b0;
      timeout      <= 1'b0;
      mod_ready    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // timeout is a pulse: it is only raised on the finishing tick below.
      timeout <= 1'b0;
      if (stop) begin
        state        <= IDLE;
        psc          <= '0;
        timer_remain <= '0;
        heat_en      <= 1'b0;
        mod_ready    <= 1'b0;
        busy         <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && door && (timp_setat != '0)) begin
              state        <= RUN;
              timer_remain <= timp_setat;
              psc          <= '0;
              heat_en      <= 1'b1;
              busy         <= 1'b1;
            end
          end

          RUN: begin
            // Door open wins over a due tick: counters freeze as they are.
            if (!door) begin
              state   <= PAUSE;
              heat_en <= 1'b0;
            end else if (psc == PSC_LAST) begin
              psc <= '0;
              if (timer_remain != '0) begin
                timer_remain <= timer_remain - 1'b1;
                if (timer_remain == TIME_W'(1)) begin
                  state     <= DONE;
                  heat_en   <= 1'b0;
                  busy      <= 1'b0;
                  mod_ready <= 1'b1;
                  timeout   <= 1'b1;
                end
              end
            end else begin
              psc <= psc + 1'b1;
            end
          end

          PAUSE: begin
            // The resume edge itself does not advance psc, so time spent
            // outside RUN never counts toward cook time.
            if (resume) begin
              state   <= RUN;
              heat_en <= 1'b1;
            end
          end

          DONE: begin
            if (!door) begin
              state     <= IDLE;
              mod_ready <= 1'b0;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oven_cook_timer.sv
module tb_oven_cook_timer;

  localparam int C  = 4;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          stop;
  logic          door;
  logic [TW-1:0] timp_setat;
  logic [TW-1:0] timer_remain;
  logic          heat_en;
  logic          timeout;
  logic          mod_ready;
  logic          busy;

  oven_cook_timer #(.CLK_PER_SEC(C), .TIME_W(TW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .door         (door),
    .timp_setat   (timp_setat),
    .timer_remain (timer_remain),
    .heat_en      (heat_en),
    .timeout      (timeout),
    .mod_ready    (mod_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // cyc == number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]   at;
    logic [TW-1:0] remain;
    logic          heat;
    logic          to;
    logic          rdy;
    logic          bsy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Expected outputs right after rising edge number 'at'.
  task automatic push(input int at, input string nm, input int r,
                      input logic h, input logic t, input logic m, input logic b);
    exp_t e;
    e.at     = at;
    e.remain = TW'(r);
    e.heat   = h;
    e.to     = t;
    e.rdy    = m;
    e.bsy    = b;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are stable at the falling edge.
  exp_t  cur;
  string cur_nm;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && int'(exp_q[0].at) <= cyc) begin
      cur    = exp_q.pop_front();
      cur_nm = name_q.pop_front();
      n_tests++;
      if (int'(cur.at) != cyc) begin
        n_fail++;
        $display("FAIL %s: check slot %0d missed at edge %0d", cur_nm, cur.at, cyc);
      end else if (timer_remain !== cur.remain || heat_en !== cur.heat ||
                   timeout !== cur.to || mod_ready !== cur.rdy || busy !== cur.bsy) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got remain=%0d heat=%b to=%b rdy=%b busy=%b, want remain=%0d heat=%b to=%b rdy=%b busy=%b",
                 cur_nm, cyc, timer_remain, heat_en, timeout, mod_ready, busy,
                 cur.remain, cur.heat, cur.to, cur.rdy, cur.bsy);
      end
    end
  end

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  int k;
  int r;

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; door = 1'b1; timp_setat = '0;
    repeat (2) @(negedge clk);
    push(cyc + 1, "reset_state", 0, 0, 0, 0, 0);
    goto(cyc + 1);
    reset = 1'b1;
    goto(cyc + 1);

    // Basic countdown, 2 s at 4 clocks/s.
    timp_setat = 8'd2; start = 1'b1; k = cyc + 1;
    push(k,     "s1_load",        2, 1, 0, 0, 1);
    push(k + 3, "s1_before_tick", 2, 1, 0, 0, 1);
    push(k + 4, "s1_tick1",       1, 1, 0, 0, 1);
    push(k + 7, "s1_before_end",  1, 1, 0, 0, 1);
    push(k + 8, "s1_timeout",     0, 0, 1, 1, 0);
    push(k + 9, "s1_pulse_end",   0, 0, 0, 1, 0);
    goto(k); start = 1'b0;
    timp_setat = 8'd9;
    goto(k + 10);
    timp_setat = 8'd5; start = 1'b1;
    push(k + 11, "s1_start_in_done", 0, 0, 0, 1, 0);
    goto(k + 11); start = 1'b0; door = 1'b0;
    push(k + 12, "s1_door_to_idle", 0, 0, 0, 0, 0);
    goto(k + 12); door = 1'b1;
    goto(k + 13);

    // Pause / resume, 3 s; door open for 5 edges starting at psc=2 of second 2.
    timp_setat = 8'd3; start = 1'b1; k = cyc + 1;
    push(k + 4, "s2_tick1",       2, 1, 0, 0, 1);
    push(k + 7, "s2_pause",       2, 0, 0, 0, 1);
    push(k + 10, "s2_start_door_open", 2, 0, 0, 0, 1);
`ifdef OVEN_TIMER_AUTORESUME_EN
    r = k + 12;
`else
    push(k + 12, "s2_close_no_resume", 2, 0, 0, 0, 1);
    r = k + 14;
`endif
    push(r,     "s2_resume",       2, 1, 0, 0, 1);
    push(r + 1, "s2_psc_held",     2, 1, 0, 0, 1);
    push(r + 2, "s2_tick_after",   1, 1, 0, 0, 1);
    push(r + 5, "s2_before_end",   1, 1, 0, 0, 1);
    push(r + 6, "s2_timeout",      0, 0, 1, 1, 0);
    goto(k); start = 1'b0; timp_setat = 8'd50;
    goto(k + 6); door = 1'b0;
    goto(k + 9); start = 1'b1;
    goto(k + 10); start = 1'b0;
    goto(k + 11); door = 1'b1;
`ifndef OVEN_TIMER_AUTORESUME_EN
    goto(k + 13); start = 1'b1;
    goto(k + 14); start = 1'b0;
`endif
    goto(r + 7); door = 1'b0;
    push(r + 8, "s2_door_to_idle", 0, 0, 0, 0, 0);
    goto(r + 8); door = 1'b1;

    // Ignored starts: door open, then zero cook time.
    door = 1'b0; timp_setat = 8'd5; start = 1'b1; k = cyc + 1;
    push(k, "s3_start_door_open", 0, 0, 0, 0, 0);
    goto(k); door = 1'b1; timp_setat = 8'd0;
    push(k + 1, "s3_start_zero_time", 0, 0, 0, 0, 0);
    goto(k + 1); start = 1'b0;

    // Stop priority: start+stop in IDLE, then stop mid-run at remain=5.
    timp_setat = 8'd5; start = 1'b1; stop = 1'b1; k = cyc + 1;
    push(k, "s4_start_and_stop", 0, 0, 0, 0, 0);
    goto(k); stop = 1'b0; timp_setat = 8'd7; k = cyc + 1;
    push(k,      "s4_load7",       7, 1, 0, 0, 1);
    push(k + 9,  "s4_before_stop", 5, 1, 0, 0, 1);
    push(k + 10, "s4_stop",        0, 0, 0, 0, 0);
    push(k + 12, "s4_stays_idle",  0, 0, 0, 0, 0);
    goto(k); start = 1'b0;
    goto(k + 9); stop = 1'b1;
    goto(k + 10); stop = 1'b0;
    goto(k + 12);

    // Door opens on the very edge a tick would finish the countdown.
    timp_setat = 8'd1; start = 1'b1; k = cyc + 1;
    push(k + 3, "s5_before_tick", 1, 1, 0, 0, 1);
    push(k + 4, "s5_pause_on_tick", 1, 0, 0, 0, 1);
    push(k + 5, "s5_pause_hold",  1, 0, 0, 0, 1);
    push(k + 6, "s5_stop_in_pause", 0, 0, 0, 0, 0);
    goto(k); start = 1'b0;
    goto(k + 3); door = 1'b0;
    goto(k + 5); stop = 1'b1;
    goto(k + 6); stop = 1'b0; door = 1'b1;

    // Reset mid-run, then a fresh start reloads normally.
    timp_setat = 8'd3; start = 1'b1; k = cyc + 1;
    push(k + 2, "s6_running",   3, 1, 0, 0, 1);
    push(k + 3, "s6_reset",     0, 0, 0, 0, 0);
    goto(k); start = 1'b0;
    goto(k + 2); reset = 1'b0;
    goto(k + 3); reset = 1'b1;
    timp_setat = 8'd1; start = 1'b1; k = cyc + 1;
    push(k,     "s6_reload",    1, 1, 0, 0, 1);
    push(k + 4, "s6_timeout",   0, 0, 1, 1, 0);
    goto(k); start = 1'b0;
    goto(k + 6);

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks left unserviced, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
